// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and NZCV flag bit positions.
// Latency: n/a (types and constants only). Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// 1-bit full adder cell used for one bit of the serial datapath.
// Latency: purely combinational. Backpressure: none.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/nserial_subtractor.sv
// Bit-serial N-bit subtractor R = A - B with NZCV flags, LSB first.
// Latency: done pulses N+1 cycles after the accepting edge; one result per N+2 cycles.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module nserial_subtractor
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] R,
    output logic [3:0]   flag
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   r_q, r_d;
    logic [3:0]     flag_q, flag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           fa_s;
    logic           fa_cout;

    // Subtraction as A + ~B + 1: the inverted subtrahend bit feeds the adder,
    // and the carry is preset to 1 when an operation is accepted.
    serial_fa_cell u_fa (
        .a    (a_q[0]),
        .b    (~b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        r_d     = r_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[N-1:1]};
                a_d     = {1'b0, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the last bit a_q[0]/b_q[0] still hold the operand sign bits.
                    state_d = DONE;
                    r_d     = res_d;
                    flag_d  = pack_nzcv(fa_s,
                                        (res_d == '0),
                                        fa_cout,
                                        (a_q[0] != b_q[0]) && (fa_s != a_q[0]));
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            r_q     <= '0;
            flag_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            r_q     <= r_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign flag = flag_q;

endmodule

// File: tb/tb_nserial_subtractor.sv
// Scoreboarded bench for nserial_subtractor (N=8): result, flags and done timing.
module tb_nserial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] R;
    logic [3:0]   flag;

    nserial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .flag  (flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] r;
        logic [3:0]   f;
        int           at;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, req, cyc);
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int at);
        exp_t e;
        logic [N:0] wide;
        wide = {1'b0, a} - {1'b0, b};
        e.r  = wide[N-1:0];
        e.f  = {e.r[N-1], (e.r == '0), (a >= b),
                (a[N-1] != b[N-1]) && (e.r[N-1] != a[N-1])};
        e.at = at;
        return e;
    endfunction

    // Done must only appear when something is expected, exactly on its cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("R", {24'd0, R}, {24'd0, e.r});
                check_eq("flag", {28'd0, flag}, {28'd0, e.f});
                check_eq("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Start sampled at the next edge (cyc+1); done is visible N+1 edges after that.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_accept);
        A     = a;
        B     = b;
        start = 1'b1;
        if (expect_accept) exp_q.push_back(model(a, b, cyc + N + 2));
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_R", {24'd0, R}, 32'd0);
        check_eq("rst_flag", {28'd0, flag}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors, each issued in the IDLE cycle right after the previous done.
        do_op(8'h05, 8'h03, 1'b1);
        check_eq("busy_run", {31'd0, busy}, 32'd1);
        wait_drain(40);
        do_op(8'h03, 8'h05, 1'b1); wait_drain(40);
        do_op(8'h80, 8'h01, 1'b1); wait_drain(40);
        do_op(8'h7F, 8'hFF, 1'b1); wait_drain(40);
        do_op(8'h5A, 8'h5A, 1'b1); wait_drain(40);
        check_eq("hold_R", {24'd0, R}, 32'h00);
        check_eq("hold_flag", {28'd0, flag}, 32'h6);
        tick();
        tick();

        // Second start while busy must be dropped and leave the first result intact.
        do_op(8'h10, 8'h01, 1'b1);
        tick();
        do_op(8'hFF, 8'hFF, 1'b0);
        wait_drain(40);
        repeat (N + 4) tick();
        check_eq("dropped_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("dropped_keep_R", {24'd0, R}, 32'h0F);

        // Reset in the middle of RUN discards the operation.
        do_op(8'hC3, 8'h21, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        start = 1'b1;
        exp_q.delete();
        tick();
        start = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_R", {24'd0, R}, 32'd0);
        check_eq("midrst_flag", {28'd0, flag}, 32'd0);
        rst = 1'b0;
        repeat (N + 4) tick();
        do_op(8'h20, 8'h07, 1'b1); wait_drain(40);

        // Random back-to-back operations.
        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra : 8'($urandom);
            do_op(ra, rb, 1'b1);
            wait_drain(40);
        end

        repeat (N + 4) tick();
        check_eq("final_queue_empty", exp_q.size(), 0);
        check_eq("done_count", n_done, 19);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
